// File: rtl/arrow_chart_sequencer_if.sv
// Control, chart-write and launch signals between game control and the arrow sequencer.
// All strobes (frame_i, start_i, stop_i, wr_v_i) are single-cycle, ready-less: they act on the edge where they are high.
interface arrow_chart_sequencer_if #(
    parameter int LANES = 4,
    parameter int STEPW = 5
);
    logic             frame_i;
    logic             start_i;
    logic             stop_i;
    logic             wr_v_i;
    logic [STEPW-1:0] wr_addr_i;
    logic [LANES-1:0] wr_data_i;
    logic [LANES-1:0] launch_o;
    logic [STEPW-1:0] step_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output frame_i, start_i, stop_i, wr_v_i, wr_addr_i, wr_data_i,
        input  launch_o, step_o, busy_o, done_o
    );

    modport slave (
        input  frame_i, start_i, stop_i, wr_v_i, wr_addr_i, wr_data_i,
        output launch_o, step_o, busy_o, done_o
    );
endinterface

// File: rtl/arrow_chart_sequencer.sv
// Step sequencer: walks a per-step lane-mask chart at STEP_FRAMES frames per step and
// emits one-cycle launch pulses for the arrow lanes.
module arrow_chart_sequencer #(
    parameter int LANES       = 4,
    parameter int STEPS       = 32,
    parameter int STEP_FRAMES = 15,
    parameter int LOOP        = 1,
    parameter int STEPW       = $clog2(STEPS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    arrow_chart_sequencer_if.slave bus,
    output logic [1:0]             dbg_state_o
);
    localparam int FCW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [STEPW-1:0] LAST_STEP  = STEPW'(STEPS - 1);
    localparam logic [FCW-1:0]   LAST_FRAME = FCW'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [STEPW-1:0] step_q, step_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [LANES-1:0] launch_q, launch_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic [LANES-1:0] chart_q [STEPS];

    // Writes land at the edge, so a same-cycle read of that entry still sees the old mask.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STEPS; i++) begin
                chart_q[i] <= '0;
            end
        end else if (bus.wr_v_i && (int'(bus.wr_addr_i) < STEPS)) begin
            chart_q[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        fcnt_d   = fcnt_q;
        launch_d = '0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                    step_d  = '0;
                    fcnt_d  = '0;
                end
            end
            S_RUN: begin
                if (bus.start_i) begin
                    step_d = '0;
                    fcnt_d = '0;
                end else if (bus.frame_i) begin
                    if (fcnt_q == '0) begin
                        launch_d = chart_q[step_q];
                    end
                    if (fcnt_q == LAST_FRAME) begin
                        fcnt_d = '0;
                        if (step_q == LAST_STEP) begin
                            step_d = '0;
                            if (LOOP == 0) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = step_q + STEPW'(1);
                        end
                    end else begin
                        fcnt_d = fcnt_q + FCW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything decided above, including a same-cycle launch.
        if (bus.stop_i) begin
            state_d  = S_IDLE;
            step_d   = '0;
            fcnt_d   = '0;
            launch_d = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            fcnt_q   <= '0;
            launch_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            fcnt_q   <= fcnt_d;
            launch_q <= launch_d;
            busy_q   <= (state_d == S_RUN);
            done_q   <= done_d;
        end
    end

    assign bus.launch_o = launch_q;
    assign bus.step_o   = step_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_arrow_chart_sequencer.sv
// Directed bench: three sequencer configurations share one stimulus stream; each phase checks the relevant instance.
module tb_arrow_chart_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       frame, start, stop, wr_v;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] st_a, st_b, st_c;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_l;
    logic [3:0] walk_chart [4];
    logic [3:0] sf1_chart [4];

    always #5 clk = ~clk;

    arrow_chart_sequencer_if #(.LANES(4), .STEPW(2)) if_a ();
    arrow_chart_sequencer_if #(.LANES(4), .STEPW(2)) if_b ();
    arrow_chart_sequencer_if #(.LANES(4), .STEPW(2)) if_c ();

    assign if_a.frame_i = frame;   assign if_b.frame_i = frame;   assign if_c.frame_i = frame;
    assign if_a.start_i = start;   assign if_b.start_i = start;   assign if_c.start_i = start;
    assign if_a.stop_i  = stop;    assign if_b.stop_i  = stop;    assign if_c.stop_i  = stop;
    assign if_a.wr_v_i  = wr_v;    assign if_b.wr_v_i  = wr_v;    assign if_c.wr_v_i  = wr_v;
    assign if_a.wr_addr_i = wr_addr; assign if_b.wr_addr_i = wr_addr; assign if_c.wr_addr_i = wr_addr;
    assign if_a.wr_data_i = wr_data; assign if_b.wr_data_i = wr_data; assign if_c.wr_data_i = wr_data;

    // a: non-looping, 2 frames/step; b: looping, 2 frames/step; c: looping, 1 frame/step.
    arrow_chart_sequencer #(.LANES(4), .STEPS(4), .STEP_FRAMES(2), .LOOP(0), .STEPW(2)) u_a (
        .clk_i(clk), .reset_i(rst), .bus(if_a), .dbg_state_o(st_a));
    arrow_chart_sequencer #(.LANES(4), .STEPS(4), .STEP_FRAMES(2), .LOOP(1), .STEPW(2)) u_b (
        .clk_i(clk), .reset_i(rst), .bus(if_b), .dbg_state_o(st_b));
    arrow_chart_sequencer #(.LANES(4), .STEPS(4), .STEP_FRAMES(1), .LOOP(1), .STEPW(2)) u_c (
        .clk_i(clk), .reset_i(rst), .bus(if_c), .dbg_state_o(st_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wr_v = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_v = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // One frame tick, optionally with a chart write in the same cycle; returns one cycle later.
    task automatic tick(input logic w, input logic [1:0] a, input logic [3:0] d);
        frame = 1'b1; wr_v = w; wr_addr = a; wr_data = d;
        @(negedge clk);
        frame = 1'b0; wr_v = 1'b0;
    endtask

    initial begin
        walk_chart = '{4'd1, 4'd2, 4'd4, 4'd8};
        sf1_chart  = '{4'd3, 4'd0, 4'd12, 4'd5};
        rst = 1'b1; frame = 1'b0; start = 1'b0; stop = 1'b0;
        wr_v = 1'b0; wr_addr = '0; wr_data = '0;
        gap(3);
        rst = 1'b0;

        // Reset after random activity
        for (int i = 0; i < 30; i++) begin
            frame   = 1'($urandom_range(0, 1));
            start   = 1'($urandom_range(0, 1));
            stop    = (i % 7 == 6);
            wr_v    = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        frame = 1'b0; start = 1'b0; stop = 1'b0; wr_v = 1'b0;
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        chk("rst_launch", if_a.launch_o, 0);
        chk("rst_step", if_a.step_o, 0);
        chk("rst_busy", if_a.busy_o, 0);
        chk("rst_done", if_a.done_o, 0);
        chk("rst_state", st_a, 0);
        pulse_start();
        chk("rst_start_busy", if_a.busy_o, 1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 2'd0, 4'd0);
            chk("rst_chart_a", if_a.launch_o, 0);
            chk("rst_chart_c", if_c.launch_o, 0);
            gap(1);
        end
        pulse_stop();
        chk("stop_busy", if_a.busy_o, 0);

        // Basic walk on a, identical walk on b for the first 8 ticks
        for (int i = 0; i < 4; i++) write(2'(i), walk_chart[i]);
        pulse_start();
        chk("walk_busy", if_a.busy_o, 1);
        chk("walk_step0", if_a.step_o, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 2'd0, 4'd0);
            exp_l = (k % 2 == 1) ? walk_chart[(k - 1) / 2] : 4'd0;
            chk("walk_launch", if_a.launch_o, exp_l);
            chk("loop_launch", if_b.launch_o, exp_l);
            chk("walk_step", if_a.step_o, (k / 2) % 4);
            chk("walk_done", if_a.done_o, (k == 8) ? 1 : 0);
            chk("loop_done", if_b.done_o, 0);
            if (k == 8) chk("walk_busy_fall", if_a.busy_o, 0);
            gap(1);
            chk("walk_pulse_width", if_a.launch_o, 0);
            chk("walk_done_width", if_a.done_o, 0);
            gap(8);
        end
        chk("walk_idle", st_a, 0);

        // Loop continues on b
        for (int k = 9; k <= 10; k++) begin
            tick(1'b0, 2'd0, 4'd0);
            chk("loop_launch", if_b.launch_o, (k == 9) ? 1 : 0);
            chk("loop_step", if_b.step_o, (k == 9) ? 0 : 1);
            chk("loop_done", if_b.done_o, 0);
            chk("loop_busy", if_b.busy_o, 1);
            chk("idle_no_launch", if_a.launch_o, 0);
            gap(9);
        end
        pulse_stop();

        // Stop priority
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", if_a.busy_o, 0);
        chk("startstop_state", st_a, 0);
        pulse_start();
        tick(1'b0, 2'd0, 4'd0);
        gap(2);
        tick(1'b0, 2'd0, 4'd0);
        gap(2);
        chk("pre_stop_step", if_a.step_o, 1);
        frame = 1'b1; stop = 1'b1;
        @(negedge clk);
        frame = 1'b0; stop = 1'b0;
        chk("stop_launch", if_a.launch_o, 0);
        chk("stop_busy2", if_a.busy_o, 0);
        chk("stop_step", if_a.step_o, 0);
        chk("stop_done", if_a.done_o, 0);

        // Write during run
        pulse_start();
        tick(1'b0, 2'd0, 4'd0);
        chk("wr_launch0", if_a.launch_o, 1);
        gap(3);
        tick(1'b0, 2'd0, 4'd0);
        gap(3);
        chk("wr_at_step1", if_a.step_o, 1);
        write(2'd2, 4'hf);
        tick(1'b0, 2'd0, 4'd0);
        chk("wr_launch1", if_a.launch_o, 2);
        gap(3);
        tick(1'b0, 2'd0, 4'd0);
        gap(3);
        tick(1'b0, 2'd0, 4'd0);
        chk("wr_future_step", if_a.launch_o, 4'hf);
        gap(3);
        tick(1'b0, 2'd0, 4'd0);
        gap(3);
        tick(1'b1, 2'd3, 4'h3);
        chk("wr_same_cycle_old", if_a.launch_o, 8);
        gap(3);
        pulse_stop();

        // One frame per step on c
        for (int i = 0; i < 4; i++) begin
            write(2'(i), sf1_chart[i]);
            exp_q.push_back(sf1_chart[i]);
        end
        pulse_start();
        frame = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sf1_launch", if_c.launch_o, exp_q.pop_front());
        end
        frame = 1'b0;
        gap(1);
        chk("sf1_gap", if_c.launch_o, 0);
        chk("sf1_wrap_step", if_c.step_o, 0);

        // Restart while running suppresses the same-cycle launch
        tick(1'b0, 2'd0, 4'd0);
        chk("restart_pre", if_c.launch_o, 3);
        frame = 1'b1; start = 1'b1;
        @(negedge clk);
        frame = 1'b0; start = 1'b0;
        chk("restart_launch", if_c.launch_o, 0);
        chk("restart_step", if_c.step_o, 0);
        chk("restart_busy", if_c.busy_o, 1);
        tick(1'b0, 2'd0, 4'd0);
        chk("restart_relaunch", if_c.launch_o, 3);
        pulse_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
